// File: rtl/image_ram_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : image_ram_loader_if
//  Description : Byte-stream and RAM-write bundle for the image RAM loader.
//                The slave modport faces the loader. The master modport faces
//                the upstream byte source and the RAM / processor side.
//  Revision    : 1.0  initial release
// ============================================================================
interface image_ram_loader_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
);
   logic              load_start;
   logic              in_valid;
   logic [7:0]        in_byte;
   logic              in_ready;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic              busy;
   logic              pro_select;

   modport master (
      output load_start, in_valid, in_byte,
      input  in_ready, ram_we, ram_addr, ram_wdata, busy, pro_select
   );

   modport slave (
      input  load_start, in_valid, in_byte,
      output in_ready, ram_we, ram_addr, ram_wdata, busy, pro_select
   );
endinterface
`default_nettype wire

// File: rtl/image_ram_loader.sv
`default_nettype none
// ============================================================================
//  Module      : image_ram_loader
//  Description : Packs an incoming byte stream into 16-bit words {hi, lo},
//                writes them to sequential RAM addresses starting at 0, and
//                raises pro_select once the last word has been written.
//  Revision    : 1.0  initial release
// ============================================================================
module image_ram_loader #(
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 16,
   parameter int NUM_WORDS = 256
) (
   input  logic                 clk,
   input  logic                 rst,
   image_ram_loader_if.slave    bus
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LO   = 3'd1,
      S_HI   = 3'd2,
      S_WR   = 3'd3,
      S_DONE = 3'd4
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

   state_t            state_q,      state_d;
   logic [7:0]        lo_byte_q,    lo_byte_d;
   logic [ADDR_W-1:0] ram_addr_q,   ram_addr_d;
   logic [DATA_W-1:0] ram_wdata_q,  ram_wdata_d;
   logic              ram_we_q,     ram_we_d;
   logic              busy_q,       busy_d;
   logic              pro_select_q, pro_select_d;
   logic              in_ready;

   // Ready is a pure decode of the registered state, so no input reaches an output combinationally.
   assign in_ready = (state_q == S_LO) || (state_q == S_HI);

   // State register and registered outputs; reset discards any half-assembled word.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         lo_byte_q    <= '0;
         ram_addr_q   <= '0;
         ram_wdata_q  <= '0;
         ram_we_q     <= 1'b0;
         busy_q       <= 1'b0;
         pro_select_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         lo_byte_q    <= lo_byte_d;
         ram_addr_q   <= ram_addr_d;
         ram_wdata_q  <= ram_wdata_d;
         ram_we_q     <= ram_we_d;
         busy_q       <= busy_d;
         pro_select_q <= pro_select_d;
      end
   end

   // Next-state and next-output logic; ram_we only survives the single WR cycle.
   always_comb begin
      state_d      = state_q;
      lo_byte_d    = lo_byte_q;
      ram_addr_d   = ram_addr_q;
      ram_wdata_d  = ram_wdata_q;
      ram_we_d     = 1'b0;
      busy_d       = busy_q;
      pro_select_d = pro_select_q;
      case (state_q)
         S_IDLE: begin
            if (bus.load_start) begin
               ram_addr_d = '0;
               busy_d     = 1'b1;
               state_d    = S_LO;
            end
         end
         S_LO: begin
            if (bus.in_valid && in_ready) begin
               lo_byte_d = bus.in_byte;
               state_d   = S_HI;
            end
         end
         S_HI: begin
            if (bus.in_valid && in_ready) begin
               ram_wdata_d = {bus.in_byte, lo_byte_q};
               ram_we_d    = 1'b1;
               state_d     = S_WR;
            end
         end
         S_WR: begin
            if (ram_addr_q == LAST_ADDR) begin
               busy_d       = 1'b0;
               pro_select_d = 1'b1;
               state_d      = S_DONE;
            end else begin
               ram_addr_d = ram_addr_q + ADDR_W'(1);
               state_d    = S_LO;
            end
         end
         S_DONE: begin
            // A new load takes the RAM back from the processor.
            if (bus.load_start) begin
               pro_select_d = 1'b0;
               ram_addr_d   = '0;
               busy_d       = 1'b1;
               state_d      = S_LO;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign bus.in_ready   = in_ready;
   assign bus.ram_we     = ram_we_q;
   assign bus.ram_addr   = ram_addr_q;
   assign bus.ram_wdata  = ram_wdata_q;
   assign bus.busy       = busy_q;
   assign bus.pro_select = pro_select_q;

endmodule
`default_nettype wire
